// File: rtl/weight_fifo_sequencer.sv
// Weight FIFO sequencer: drives per-column FIFO enables that shift a weight tile into the
// MMU, either all columns together (parallel) or diagonally staggered (MSB column first).
// Handshake is start/busy/done. An upstream stall freezes sequencing.
// Optional feature: define FIFO_CTRL_CYCLE_CNT_EN to add the load_cycles output. It reports
// the number of cycles from accepted start to the done pulse.
module weight_fifo_sequencer #(
   parameter int unsigned WIDTH = 16,
   localparam int unsigned ROW_W = $clog2(WIDTH + 1),
   localparam int unsigned CNT_W = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [ROW_W-1:0] num_rows,
   input  logic             stall,
   output logic [WIDTH-1:0] fifo_en,
   output logic             weight_write,
   output logic             busy,
   output logic             done
`ifdef FIFO_CTRL_CYCLE_CNT_EN
   ,
   output logic [15:0]      load_cycles
`endif
);

   typedef enum logic [1:0] {StIdle, StPar, StStag, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   en_q, en_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ROW_W-1:0]   rows_q, rows_d;

   logic [ROW_W-1:0]   rows_eff;
   logic [CNT_W-1:0]   rows_ext;
   logic [CNT_W-1:0]   cnt_inc;
   logic [CNT_W-1:0]   par_last;
   logic [CNT_W-1:0]   stag_last;

   // Row count normalisation and last-cycle indices for both modes
   always_comb begin
      rows_eff = num_rows;
      if (num_rows == '0 || num_rows > ROW_W'(WIDTH)) begin
         rows_eff = ROW_W'(WIDTH);
      end
      rows_ext  = CNT_W'(rows_q);
      cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      par_last  = rows_ext - CNT_W'(1);
      stag_last = rows_ext + CNT_W'(WIDTH - 2);
   end

   // State, enable pattern, cycle index and latched row count
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         en_q    <= '0;
         cnt_q   <= '0;
         rows_q  <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
         rows_q  <= rows_d;
      end
   end

   // Next-state: cnt_q is the index t of the pattern currently held in en_q
   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      cnt_d   = cnt_q;
      rows_d  = rows_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               rows_d = rows_eff;
               cnt_d  = '0;
               if (mode) begin
                  state_d = StStag;
                  en_d    = {1'b1, {(WIDTH - 1){1'b0}}};
               end else begin
                  state_d = StPar;
                  en_d    = '1;
               end
            end
         end
         StPar: begin
            if (!stall) begin
               if (cnt_q == par_last) begin
                  state_d = StDone;
                  en_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         StStag: begin
            if (!stall) begin
               if (cnt_q == stag_last) begin
                  state_d = StDone;
                  en_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
                  // A new column starts only while t+1 < N; older columns age out via the shift
                  en_d  = {(cnt_inc < rows_ext), en_q[WIDTH-1:1]};
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            en_d    = '0;
         end
         default: begin
            state_d = StIdle;
            en_d    = '0;
         end
      endcase
   end

   // Outputs: the stall masks enables combinationally so no FIFO pops while upstream is not ready
   always_comb begin
      fifo_en      = stall ? '0 : en_q;
      weight_write = |fifo_en;
      busy         = (state_q != StIdle);
      done         = (state_q == StDone);
   end

`ifdef FIFO_CTRL_CYCLE_CNT_EN
   logic [15:0] cyc_q, cyc_d;
   logic [15:0] load_q, load_d;

   // Cycle count since accepted start; the done cycle itself is included
   always_comb begin
      cyc_d  = cyc_q;
      load_d = load_q;
      unique case (state_q)
         StIdle:        if (start) cyc_d = 16'd1;
         StPar, StStag: if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
         StDone:        load_d = cyc_q;
         default:       cyc_d = cyc_q;
      endcase
   end

   // Cycle counter and reported load length
   always_ff @(posedge clk) begin
      if (!reset) begin
         cyc_q  <= '0;
         load_q <= '0;
      end else begin
         cyc_q  <= cyc_d;
         load_q <= load_d;
      end
   end

   assign load_cycles = load_q;
`endif

endmodule

// File: tb/tb_weight_fifo_sequencer.sv
// Directed testbench for weight_fifo_sequencer (WIDTH=16). Inputs are driven at the falling
// edge and outputs are sampled 1ns later, away from the active rising edge.
module tb_weight_fifo_sequencer;

   localparam int unsigned WIDTH = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              mode;
   logic [4:0]        num_rows;
   logic              stall;
   logic [WIDTH-1:0]  fifo_en;
   logic              weight_write;
   logic              busy;
   logic              done;
`ifdef FIFO_CTRL_CYCLE_CNT_EN
   logic [15:0]       load_cycles;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   weight_fifo_sequencer #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .mode         (mode),
      .num_rows     (num_rows),
      .stall        (stall),
      .fifo_en      (fifo_en),
      .weight_write (weight_write),
      .busy         (busy),
      .done         (done)
`ifdef FIFO_CTRL_CYCLE_CNT_EN
      ,
      .load_cycles  (load_cycles)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Column i (j = WIDTH-1-i) is enabled for j <= t < j+n
   function automatic logic [WIDTH-1:0] stag_pat(input int t, input int n);
      logic [WIDTH-1:0] p;
      p = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (t >= (WIDTH - 1 - i) && t < (WIDTH - 1 - i + n)) p[i] = 1'b1;
      end
      return p;
   endfunction

   // One full load: start, every pattern cycle, optional stall window, done pulse, return to idle
   task automatic run_load(input logic m, input logic [4:0] nr, input int n, input int stall_at,
                           input int stall_len, input bit poke_done);
      int total;
      int stalled;
      logic [WIDTH-1:0] exp;
      total   = m ? (WIDTH - 1 + n) : n;
      stalled = 0;
      @(negedge clk);
      start = 1'b1; mode = m; num_rows = nr;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < total; t++) begin
         if (t == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               stall = 1'b1;
               #1;
               check_eq("stall_en", 32'(fifo_en), 32'h0);
               check_eq("stall_ww", 32'(weight_write), 32'h0);
               check_eq("stall_busy", 32'(busy), 32'h1);
               stalled++;
               @(negedge clk);
            end
         end
         stall = 1'b0;
         #1;
         exp = m ? stag_pat(t, n) : {WIDTH{1'b1}};
         check_eq($sformatf("en_t%0d", t), 32'(fifo_en), 32'(exp));
         check_eq("ww", 32'(weight_write), 32'h1);
         check_eq("busy", 32'(busy), 32'h1);
         check_eq("done_early", 32'(done), 32'h0);
         @(negedge clk);
      end
      #1;
      check_eq("done_pulse", 32'(done), 32'h1);
      check_eq("done_en", 32'(fifo_en), 32'h0);
      check_eq("done_ww", 32'(weight_write), 32'h0);
      check_eq("done_busy", 32'(busy), 32'h1);
      if (poke_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check_eq("after_done", 32'(done), 32'h0);
      check_eq("after_busy", 32'(busy), 32'h0);
      check_eq("after_en", 32'(fifo_en), 32'h0);
`ifdef FIFO_CTRL_CYCLE_CNT_EN
      check_eq("load_cycles", 32'(load_cycles), 32'(total + 1 + stalled));
`endif
   endtask

   initial begin
      reset = 1'b0; start = 1'b1; mode = 1'b0; num_rows = 5'd16; stall = 1'b0;
      // Reset held with start high: nothing may start
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_en", 32'(fifo_en), 32'h0);
      check_eq("rst_ww", 32'(weight_write), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_done", 32'(done), 32'h0);
`ifdef FIFO_CTRL_CYCLE_CNT_EN
      check_eq("rst_load", 32'(load_cycles), 32'h0);
`endif
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1;
      check_eq("idle_busy", 32'(busy), 32'h0);
      check_eq("idle_en", 32'(fifo_en), 32'h0);

      // Parallel N=16, start poked in DONE must be ignored
      run_load(1'b0, 5'd16, 16, -1, 0, 1'b1);
      // Stagger N=16
      run_load(1'b1, 5'd16, 16, -1, 0, 1'b0);
      // Stagger N=4
      run_load(1'b1, 5'd4, 4, -1, 0, 1'b0);
      // Stagger N=16 with a 3-cycle stall at t=5
      run_load(1'b1, 5'd16, 16, 5, 3, 1'b0);
      // Parallel N=3, short load
      run_load(1'b0, 5'd3, 3, -1, 0, 1'b0);
      // Oversized row count clamps to WIDTH
      run_load(1'b0, 5'd20, 16, -1, 0, 1'b0);

      // Start during a stagger load is ignored; reset mid-load aborts with no done
      @(negedge clk);
      start = 1'b1; mode = 1'b1; num_rows = 5'd16;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t <= 8; t++) begin
         #1;
         check_eq($sformatf("abort_en_t%0d", t), 32'(fifo_en), 32'(stag_pat(t, 16)));
         if (t == 8) begin
            start = 1'b1; mode = 1'b0; num_rows = 5'd4;
         end
         @(negedge clk);
      end
      start = 1'b0;
      #1;
      check_eq("ign_start_en", 32'(fifo_en), 32'(stag_pat(9, 16)));
      check_eq("ign_start_busy", 32'(busy), 32'h1);
      reset = 1'b0;
      @(negedge clk);
      #1;
      check_eq("abort_en", 32'(fifo_en), 32'h0);
      check_eq("abort_ww", 32'(weight_write), 32'h0);
      check_eq("abort_busy", 32'(busy), 32'h0);
      check_eq("abort_done", 32'(done), 32'h0);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check_eq("post_abort_done", 32'(done), 32'h0);
         check_eq("post_abort_busy", 32'(busy), 32'h0);
      end

      // N=0 behaves as N=16
      run_load(1'b1, 5'd0, 16, -1, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
